// File: rtl/mem_bus_bridge_pkg.sv
// Shared types for the MEM-stage data bus bridge: FSM state encodings,
// fault-cause codes for debug, and the alignment helper.
package mem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } bridge_state_e;

    typedef enum logic [1:0] {
        FaultNone     = 2'd0,
        FaultMisalign = 2'd1,
        FaultBusErr   = 2'd2,
        FaultTimeout  = 2'd3
    } fault_cause_e;

    // Only word accesses exist, so any nonzero byte offset is a fault.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_timeout_cnt.sv
// bus_timeout_cnt: clearable up-counter that flags the last permitted
// wait cycle (count == TIMEOUT_CYCLES-1).
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// MEM-stage to wait-state data bus bridge with stall, misalign/bus-error/timeout
// faulting and squash handling. Optional counters behind MEM_BRIDGE_PERF_EN.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] FAULT_RDATA    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_flush,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
`ifdef MEM_BRIDGE_PERF_EN
    ,
    output logic [31:0] perf_access_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_fault_cnt
`endif
);

    bridge_state_e state_q;
    logic [31:0]   rdata_q;
    logic [31:0]   din_q;
    logic          fault_q;
    logic          drop_q;
    logic          tmo_expired;
    logic          req;

    assign req = mem_ren | mem_wen;

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != StReq),
        .en     (state_q == StReq),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
            din_q     <= '0;
            fault_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    drop_q <= 1'b0;
                    if (req && !mem_flush) begin
                        if (is_misaligned(mem_addr[1:0])) begin
                            fault_q <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_wen;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_dout;
                            state_q   <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (mem_flush) begin
                        drop_q <= 1'b1;
                    end
                    // A squashed access still finishes on the bus but never reaches DONE.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        rdata_q <= bus_rdata;
                        fault_q <= bus_err;
                        state_q <= (drop_q || mem_flush) ? StIdle : StDone;
                    end else if (tmo_expired) begin
                        bus_req <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= (drop_q || mem_flush) ? StIdle : StDone;
                    end
                end
                StDone: begin
                    din_q   <= mem_din;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            StIdle:  mem_stall = req & ~mem_flush;
            StReq:   mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    // Outside DONE the read data holds whatever was last delivered.
    assign mem_din   = (state_q == StDone) ? (fault_q ? FAULT_RDATA : rdata_q) : din_q;
    assign mem_fault = (state_q == StDone) & fault_q;

`ifdef MEM_BRIDGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_access_cnt <= '0;
            perf_stall_cnt  <= '0;
            perf_fault_cnt  <= '0;
        end else begin
            if (state_q == StDone) begin
                perf_access_cnt <= perf_access_cnt + 32'd1;
            end
            if (mem_fault) begin
                perf_fault_cnt <= perf_fault_cnt + 16'd1;
            end
            if (mem_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge with a scoreboard of expected
// completions and a configurable wait-state bus slave.
module tb_mem_bus_bridge;

    localparam int unsigned TMO = 8;
    localparam logic [31:0] FRD = 32'hDEAD_0BAD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic        mem_flush = 1'b0;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int          slave_waits = 0;
    logic        slave_never = 1'b0;
    logic        slave_err = 1'b0;
    logic [31:0] slave_rdata = '0;
    logic        force_ack = 1'b0;
    logic        ack_int = 1'b0;
    int          req_cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] din;
        logic        fault;
        logic        chk_din;
        int          stalls;
        int          req_cycles;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_bus_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .FAULT_RDATA   (FRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_flush(mem_flush),
        .mem_din  (mem_din),
        .mem_stall(mem_stall),
        .mem_fault(mem_fault),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err),
        .bus_rdata(bus_rdata)
    );

    assign bus_ack   = ack_int | force_ack;
    assign bus_err   = slave_err & bus_ack;
    assign bus_rdata = slave_rdata;

    // Slave: acks after slave_waits extra cycles of bus_req.
    always @(posedge clk) begin
        #1;
        if (!bus_req) begin
            ack_int = 1'b0;
            req_cyc = 0;
        end else if (!slave_never) begin
            ack_int = (req_cyc == slave_waits);
            req_cyc++;
        end else begin
            ack_int = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] din, input logic fault, input logic chk_din,
                            input int stalls, input int req_cycles);
        exp_t e;
        e.din        = din;
        e.fault      = fault;
        e.chk_din    = chk_din;
        e.stalls     = stalls;
        e.req_cycles = req_cycles;
        sb_q.push_back(e);
    endtask

    // Holds the request until the first non-stalled cycle, then compares it
    // against the oldest scoreboard entry and advances one cycle.
    task automatic run_access(input string tag, input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int flush_at);
        exp_t e;
        int   stalls = 0;
        int   reqc = 0;
        bit   done = 1'b0;
        mem_ren   = ren;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_dout  = wdata;
        mem_flush = 1'b0;
        #1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (bus_req) begin
                reqc++;
                check({tag, "/bus_addr"}, bus_addr, addr);
                check({tag, "/bus_we"}, {31'b0, bus_we}, {31'b0, wen});
                check({tag, "/bus_wdata"}, bus_wdata, wdata);
            end
            if (mem_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                check({tag, "/sb_nonempty"}, {31'b0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    if (e.chk_din) begin
                        check({tag, "/mem_din"}, mem_din, e.din);
                    end
                    check({tag, "/mem_fault"}, {31'b0, mem_fault}, {31'b0, e.fault});
                    check({tag, "/stall_cycles"}, stalls, e.stalls);
                    check({tag, "/req_cycles"}, reqc, e.req_cycles);
                end
            end
            if (c == flush_at) begin
                mem_flush = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                #1;
            end
        end
        check({tag, "/completed"}, {31'b0, done}, 32'd1);
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_flush = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst/bus_req", {31'b0, bus_req}, 32'd0);
        check("rst/bus_we", {31'b0, bus_we}, 32'd0);
        check("rst/bus_addr", bus_addr, 32'd0);
        check("rst/bus_wdata", bus_wdata, 32'd0);
        check("rst/mem_din", mem_din, 32'd0);
        check("rst/mem_stall", {31'b0, mem_stall}, 32'd0);
        check("rst/mem_fault", {31'b0, mem_fault}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Zero-wait read
        slave_waits = 0;
        slave_rdata = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b0, 1'b1, 2, 1);
        run_access("rd0", 1'b1, 1'b0, 32'h0000_0100, 32'h0, -1);

        // Write with three wait states
        slave_waits = 3;
        slave_rdata = 32'h5555_AAAA;
        push_exp(32'h0, 1'b0, 1'b0, 5, 4);
        run_access("wr3", 1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, -1);

        // Misaligned read: no bus access
        push_exp(FRD, 1'b1, 1'b1, 1, 0);
        run_access("misalign", 1'b1, 1'b0, 32'h0000_0102, 32'h0, -1);

        // Squash during REQ, ack on second REQ cycle
        slave_waits = 1;
        slave_rdata = 32'h1111_2222;
        push_exp(FRD, 1'b0, 1'b1, 3, 2);
        run_access("flush", 1'b1, 1'b0, 32'h0000_0108, 32'h0, 1);
        check("flush/din_held", mem_din, FRD);
        check("flush/no_fault", {31'b0, mem_fault}, 32'd0);

        // Bus error response
        slave_waits = 0;
        slave_err   = 1'b1;
        slave_rdata = 32'h7777_7777;
        push_exp(FRD, 1'b1, 1'b1, 2, 1);
        run_access("buserr", 1'b1, 1'b0, 32'h0000_010C, 32'h0, -1);
        slave_err = 1'b0;

        // Both ren and wen: treated as a write
        slave_rdata = 32'h0;
        push_exp(32'h0, 1'b0, 1'b0, 2, 1);
        run_access("rdwr", 1'b1, 1'b1, 32'h0000_0110, 32'hA5A5_A5A5, -1);

        // Back-to-back reads with no bubble
        slave_rdata = 32'h0BB0_0001;
        push_exp(32'h0BB0_0001, 1'b0, 1'b1, 2, 1);
        run_access("b2b_a", 1'b1, 1'b0, 32'h0000_0114, 32'h0, -1);
        slave_rdata = 32'h0BB0_0002;
        push_exp(32'h0BB0_0002, 1'b0, 1'b1, 2, 1);
        run_access("b2b_b", 1'b1, 1'b0, 32'h0000_0118, 32'h0, -1);

        // Timeout: slave never acks
        slave_never = 1'b1;
        push_exp(FRD, 1'b1, 1'b1, TMO + 1, TMO);
        run_access("timeout", 1'b1, 1'b0, 32'h0000_0120, 32'h0, -1);
        force_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("late_ack/bus_req", {31'b0, bus_req}, 32'd0);
            check("late_ack/mem_stall", {31'b0, mem_stall}, 32'd0);
            check("late_ack/mem_fault", {31'b0, mem_fault}, 32'd0);
            check("late_ack/mem_din", mem_din, FRD);
            @(negedge clk);
        end
        force_ack = 1'b0;
        #1;

        // Reset in the middle of REQ
        mem_ren  = 1'b1;
        mem_addr = 32'h0000_0130;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("midrst/in_req", {31'b0, bus_req}, 32'd1);
        rst_n   = 1'b0;
        mem_ren = 1'b0;
        #1;
        check("midrst/bus_req", {31'b0, bus_req}, 32'd0);
        check("midrst/mem_stall", {31'b0, mem_stall}, 32'd0);
        check("midrst/mem_din", mem_din, 32'd0);
        check("midrst/bus_addr", bus_addr, 32'd0);
        @(negedge clk);
        #1;
        rst_n       = 1'b1;
        slave_never = 1'b0;
        slave_waits = 1;
        slave_rdata = 32'h600D_0001;
        @(negedge clk);
        #1;
        push_exp(32'h600D_0001, 1'b0, 1'b1, 3, 2);
        run_access("post_rst", 1'b1, 1'b0, 32'h0000_0134, 32'h0, -1);

        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Data-memory bridge directly downstream of the 5-stage pipeline's MEM stage.
- Consumes the MEM-stage request (ren/wen/addr/write data), runs a req/ack transaction on a wait-state data bus, and returns read data on mem_din.
- Asserts mem_stall to freeze the pipeline until the access completes.
- Handles misalignment, bus error and timeout as a single-cycle fault completion.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in REQ waiting for bus_ack before abort (must be ≥2).
- FAULT_RDATA, 32'h0000_0000, value returned on mem_din for faulted reads.

Ports:
- clk  in  1  main clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_ren  in  1  MEM-stage read request
- mem_wen  in  1  MEM-stage write request
- mem_addr  in  32  byte address (word accesses only)
- mem_dout  in  32  write data from pipeline
- mem_flush  in  1  MEM-stage instruction squashed (do not deliver result)
- mem_din  out  32  read data to pipeline / WB latch
- mem_stall  out  1  combinational; 1 = hold pipeline (drive stage enables low)
- mem_fault  out  1  one-cycle pulse in DONE when access faulted
- bus_req  out  1  bus request, held until ack or abort
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address
- bus_wdata  out  32  write data
- bus_ack  in  1  transaction complete, sampled in REQ only
- bus_err  in  1  valid with bus_ack; error response
- bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_q=0, fault_q=0, counter=0. mem_din=0, mem_stall=0, mem_fault=0. Reset mid-transaction drops bus_req immediately; the bus slave must tolerate this.
- Request: req = mem_ren | mem_wen. If both are set, the access is a write.
- IDLE:
  - req=0: mem_stall=0.
  - req=1 and mem_flush=0: mem_stall=1.
    - addr[1:0]≠0: latch fault, go to DONE with no bus access.
    - Otherwise latch addr/we/wdata into bus regs, bus_req<=1, go to REQ.
  - req=1 and mem_flush=1: ignored, no bus access.
- REQ: mem_stall=1; counter increments each cycle.
  - bus_ack=1: bus_req<=0; rdata_q<=bus_rdata; fault_q<=bus_err; go to DONE.
  - counter==TIMEOUT_CYCLES-1 without ack: bus_req<=0; fault_q<=1; go to DONE.
  - mem_flush seen in REQ sets a drop flag. The bus transaction still completes (no abandon), then the FSM goes to IDLE instead of DONE.
- DONE (exactly 1 cycle): mem_stall=0, so the pipeline advances at this edge.
  - mem_din = fault_q ? FAULT_RDATA : rdata_q (writes also present rdata_q, don't-care).
  - mem_fault = fault_q. Next state IDLE; counter cleared.
- Outside DONE, mem_din holds its last value.
- Latency: zero-wait slave (ack in first REQ cycle) gives a 3-cycle access with 2 stall cycles. Each extra wait cycle adds 1.
- Back-to-back accesses: the next instruction's req is seen in IDLE the cycle after DONE; no idle bubble beyond that.
- bus_addr/bus_we/bus_wdata are stable throughout REQ.

Optional Feature:
- Macro MEM_BRIDGE_PERF_EN.
- Defined: adds outputs perf_access_cnt[31:0] (increments on entry to DONE), perf_stall_cnt[31:0] (increments each cycle mem_stall=1) and perf_fault_cnt[15:0]. All are reset to 0 by rst_n and wrap on overflow.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared header/package: FSM state encodings (ST_IDLE=2'd0, ST_REQ=2'd1, ST_DONE=2'd2) and the fault-cause codes (misalign, bus_err, timeout) for debug.
- One natural sub-module, bus_timeout_cnt: a clearable up-counter with an expiry compare against TIMEOUT_CYCLES.

Test Plan:
- Read at 0x100, slave acks 1st REQ cycle with 0xCAFE_F00D → mem_stall high 2 cycles; DONE cycle mem_din=0xCAFE_F00D, mem_fault=0.
- Write 0x1234_5678 to 0x204, ack after 3 waits → bus_we=1, bus_addr=0x204, bus_wdata stable 4 REQ cycles; stall 5 cycles total.
- Read at 0x102 (misaligned) → bus_req never asserted; DONE next cycle with mem_fault=1, mem_din=FAULT_RDATA.
- TIMEOUT_CYCLES=8, slave never acks → bus_req drops after 8 REQ cycles; mem_fault=1 in DONE; ack arriving later is ignored.
- mem_flush asserted during REQ, ack on 2nd cycle → no DONE and no mem_fault; back to IDLE, mem_din unchanged.
- Assert rst_n=0 mid-REQ → bus_req, mem_stall and state clear asynchronously; after release a fresh read completes normally.
